// File: rtl/tt_sweep.sv
// tt_sweep: truth-table sweeper for a downstream 3-input logic block.
// Each of the eight input combinations is driven for SETTLE cycles and then
// observed for HOLD cycles. The first observed value is captured into
// table_out, and any later change inside the window raises glitch. At the end
// of the sweep, pass reports whether the captured table matched the expected
// table latched at start and no glitch was seen.
module tt_sweep #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned HOLD   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       glitch,
  output logic [7:0] table_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD - 1);

  state_t     state;
  state_t     state_nx;
  logic [7:0] cnt;
  logic [2:0] idx;
  logic [7:0] exp_q;
  logic [7:0] tab_nx;
  logic       glitch_nx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: settle window, then sample window, per combination
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start) state_nx = ST_SETTLE;
      ST_SETTLE: if (cnt == SETTLE_LAST) state_nx = ST_SAMPLE;
      ST_SAMPLE: if (cnt == HOLD_LAST) state_nx = (idx == 3'd7) ? ST_DONE : ST_SETTLE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Output decode: stimulus is only presented while a sweep is in progress
  always_comb begin
    busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
    done = (state == ST_DONE);
    {in1, in2, in3} = busy ? idx : 3'b000;
  end

  // Capture/glitch view including the current sample, so pass can be
  // registered on the last sample edge and already be valid during DONE
  always_comb begin
    tab_nx    = table_out;
    glitch_nx = glitch;
    if (state == ST_SAMPLE) begin
      if (cnt == '0)                   tab_nx[idx] = dut_out;
      else if (dut_out != table_out[idx]) glitch_nx = 1'b1;
    end
  end

  // Datapath: counters, combination index, captured table and verdict
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      exp_q     <= '0;
      table_out <= '0;
      glitch    <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            exp_q     <= expected;
            idx       <= '0;
            cnt       <= '0;
            table_out <= '0;
            glitch    <= 1'b0;
            pass      <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) cnt <= '0;
          else                    cnt <= cnt + 8'd1;
        end
        ST_SAMPLE: begin
          table_out <= tab_nx;
          glitch    <= glitch_nx;
          if (cnt == HOLD_LAST) begin
            cnt <= '0;
            if (idx == 3'd7) pass <= (tab_nx == exp_q) && !glitch_nx;
            else             idx  <= idx + 3'd1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/tt_sweep.md
TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 SHALL have parameter SETTLE, default 2: cycles each input combination is driven before sampling starts (legal 1..255).
REQ-002 SHALL have parameter HOLD, default 4: cycles dut_out is sampled per combination (legal 1..255).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-006 SHALL have port expected  input  8  expected truth table; bit i = expected out for {in1,in2,in3}==i.
REQ-007 SHALL have port dut_out  input  1  output of the downstream 3-input logic block.
REQ-008 SHALL have ports in1, in2, in3  output  1 each  stimulus to the downstream block; in1 is the MSB of the combination index.
REQ-009 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at sweep end.
REQ-011 SHALL have port pass  output  1  result of the last completed sweep.
REQ-012 SHALL have port glitch  output  1  dut_out changed during a HOLD window in the last sweep.
REQ-013 SHALL have port table_out  output  8  captured truth table of the last sweep.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, SAMPLE and DONE.
REQ-015 In IDLE: {in1,in2,in3}=000, busy=0.
REQ-016 start=1 in IDLE SHALL latch expected, clear idx, table_out and glitch, clear the counter, and enter SETTLE next cycle.
REQ-017 start SHALL be ignored in every state other than IDLE; expected changes after latching SHALL be ignored.
REQ-018 In SETTLE and SAMPLE: {in1,in2,in3}=idx[2:0] and busy=1.
REQ-019 SETTLE SHALL last exactly SETTLE cycles, then go to SAMPLE with the counter cleared.
REQ-020 On the first SAMPLE cycle, table_out[idx] SHALL take dut_out.
REQ-021 On each later SAMPLE cycle, if dut_out differs from the captured bit, glitch SHALL set; it stays set until the next start.
REQ-022 The captured bit SHALL never be overwritten within a window.
REQ-023 SAMPLE SHALL last exactly HOLD cycles.
REQ-024 At the end of a SAMPLE window: if idx==7, go to DONE; otherwise idx increments and the FSM returns to SETTLE.
REQ-025 idx SHALL never wrap within a sweep.
REQ-026 DONE SHALL last one cycle with done=1, busy=0, and {in1,in2,in3}=000, then go to IDLE.
REQ-027 pass SHALL update in the DONE cycle to (table_out==latched expected) AND NOT glitch, and hold until the next start.
REQ-028 pass SHALL clear on start.
REQ-029 table_out and glitch SHALL hold after DONE until the next start.
REQ-030 Latency: start sampled at edge t -> done high in cycle t+8*(SETTLE+HOLD)+1.
REQ-031 With the defaults, that latency SHALL be 49 cycles.
REQ-032 start=1 in the DONE cycle SHALL be ignored; a new sweep needs start while in IDLE.
REQ-033 Window counters SHALL be 8-bit; no combination SHALL be skipped or repeated.

Reset
REQ-034 rst=1 at a clock edge SHALL force: state IDLE, idx=0, counter=0, in1=in2=in3=0, busy=0, done=0, pass=0, glitch=0, table_out=8'h00.
REQ-035 rst SHALL take priority over start and over any in-flight sweep; a sweep aborted by reset SHALL NOT produce done.
REQ-036 The first sweep after rst deasserts SHALL require a fresh start.

Verification
REQ-037 Scenario: defaults, model of f(i)=1 for i in {4,5,7}, expected=8'hB0, pulse start -> in sequence 000..111, each combination held 6 cycles; done at start+49; table_out=8'hB0, pass=1, glitch=0.
REQ-038 Scenario: same model, expected=8'hB1 -> table_out=8'hB0, pass=0, glitch=0.
REQ-039 Scenario: dut_out toggled on the 3rd SAMPLE cycle of combination 2, with expected matching the captured bits -> glitch=1, pass=0, table_out unchanged from the first-sample values.
REQ-040 Scenario: rst asserted for 1 cycle while busy, during combination 5 -> next cycle all outputs zero and state IDLE; no done pulse; fresh start completes normally.
REQ-041 Scenario: start pulsed repeatedly while busy and in the DONE cycle -> exactly one done per accepted start; latency still 49.
REQ-042 Scenario: SETTLE=1, HOLD=1 -> each combination lasts 2 cycles; done at start+17.
